// File: rtl/shift_sub_div_pkg.sv
// Shared constants for the shift-subtract divider: default operand width,
// controller state encoding and a counter-sizing helper.
package shift_sub_div_pkg;

    localparam int DIV_N_DEFAULT = 4;

    // Controller states; kept as plain constants so the encoding is fixed.
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_CALC = 1'b1;

    // Number of bits needed to index 0..value-1 (0 for value <= 1).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << result) < value) result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/shift_sub_divider_div_step.sv
// div_step: one combinational iteration of the restoring divider.
// Shifts the next dividend bit into the partial remainder and subtracts the
// divisor when it fits. Kept stand-alone so an unrolled or pipelined divider
// can chain copies of it.
module div_step
    import shift_sub_div_pkg::*;
#(
    parameter int N = DIV_N_DEFAULT
) (
    input  logic [N-1:0] i_rem,     // partial remainder, always < i_div
    input  logic         i_q_msb,   // next dividend bit to bring down
    input  logic [N-1:0] i_div,     // divisor
    output logic [N-1:0] o_rem,     // updated partial remainder
    output logic         o_qbit     // quotient bit produced by this step
);

    logic [N:0] w_trial;
    logic [N:0] w_div_ext;

    // Since i_rem < i_div, the trial value is < 2*i_div and fits in N+1 bits;
    // the difference after a successful subtract fits back into N bits.
    assign w_trial   = {i_rem, i_q_msb};
    assign w_div_ext = {1'b0, i_div};
    assign o_qbit    = (w_trial >= w_div_ext);
    assign o_rem     = o_qbit ? N'(w_trial - w_div_ext) : w_trial[N-1:0];

endmodule

// File: rtl/shift_sub_divider.sv
// shift_sub_divider: sequential restoring divider, 2N-bit dividend by N-bit
// divisor, one quotient bit per clock. Start/ready handshake mirrors the
// add-shift multiplier so both can sit behind the same controller.
// Optional feature: define DIV_DONE_PULSE_EN to add a one-cycle `done` output.
// N must be at least 2.
module shift_sub_divider
    import shift_sub_div_pkg::*;
#(
    parameter int N = DIV_N_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,            // asynchronous, active-low
    input  logic           start,
    input  logic [2*N-1:0] dividendBus,
    input  logic [N-1:0]   divisorBus,
    output logic [N-1:0]   quotientBus,
    output logic [N-1:0]   remainderBus,
    output logic           ovf,
    output logic           ready
`ifdef DIV_DONE_PULSE_EN
    ,
    output logic           done
`endif
);

    localparam int CW = clog2(N) + 1;

    logic [0:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_rem;       // partial remainder; its implicit top bit is always 0
    logic [N-1:0]  r_quo;       // dividend low half shifting out, quotient shifting in
    logic [N-1:0]  r_div;
    logic [N-1:0]  r_quo_out;
    logic [N-1:0]  r_rem_out;
    logic          r_ovf;

    logic [N-1:0]  w_step_rem;
    logic          w_qbit;
    logic          w_ovf_in;
    logic          w_last;
    logic          w_complete;

    // The quotient only fits N bits when the upper dividend half is below the
    // divisor; this also catches divide-by-zero.
    assign w_ovf_in   = (dividendBus[2*N-1:N] >= divisorBus);
    assign w_last     = (r_cnt == CW'(N - 1));
    assign w_complete = (r_state == S_CALC) && (r_ovf || w_last);

    div_step #(.N(N)) u_step (
        .i_rem   (r_rem),
        .i_q_msb (r_quo[N-1]),
        .i_div   (r_div),
        .o_rem   (w_step_rem),
        .o_qbit  (w_qbit)
    );

    // Controller, iteration datapath and result registers.
    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values and the update order inside the block is irrelevant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_div     <= '0;
            r_quo_out <= '0;
            r_rem_out <= '0;
            r_ovf     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_div   <= divisorBus;
                        r_rem   <= dividendBus[2*N-1:N];
                        r_quo   <= dividendBus[N-1:0];
                        r_cnt   <= '0;
                        r_ovf   <= w_ovf_in;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (r_ovf) begin
                        // Run skipped: saturated quotient, zero remainder.
                        r_quo_out <= '1;
                        r_rem_out <= '0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_rem <= w_step_rem;
                        r_quo <= {r_quo[N-2:0], w_qbit};
                        r_cnt <= r_cnt + CW'(1);
                        if (w_last) begin
                            r_quo_out <= {r_quo[N-2:0], w_qbit};
                            r_rem_out <= w_step_rem;
                            r_state   <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign quotientBus  = r_quo_out;
    assign remainderBus = r_rem_out;
    assign ovf          = r_ovf;
    assign ready        = (r_state == S_IDLE);

`ifdef DIV_DONE_PULSE_EN
    logic r_done;

    // One-cycle completion strobe, coincident with ready returning high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_done <= 1'b0;
        else      r_done <= w_complete;
    end

    assign done = r_done;
`else
    logic w_unused_complete;
    assign w_unused_complete = w_complete;
`endif

endmodule
